// File: rtl/color_request_arbiter_pkg.sv
// Shared definitions for the color request arbiter and its downstream decoder.
//
// Contents:
//   log2()          - bit width needed to hold a value; log2(COLORS-1) is the tag width
//   COLORS_DEF      - default number of request colors
//   DATA_WIDTH_DEF  - default payload width
//   TAG_WIDTH_DEF   - default tag width
//   entry_t         - {tag, data} layout of one buffered entry at default widths
package color_request_arbiter_pkg;

  // Returns the number of bits needed to represent 'value'. The result is at
  // least 1, so log2(1) still gives a usable 1-bit tag.
  function automatic int log2(input int value);
    int bits;
    bits = 0;
    for (int v = value; v > 0; v = v >> 1) begin
      bits++;
    end
    if (bits == 0) begin
      bits = 1;
    end
    return bits;
  endfunction

  localparam int COLORS_DEF     = 4;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int TAG_WIDTH_DEF  = log2(COLORS_DEF - 1);

  // The tag sits above the payload. The FIFO stores entries in this order.
  typedef struct packed {
    logic [TAG_WIDTH_DEF-1:0]  tag;
    logic [DATA_WIDTH_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/color_request_arbiter_tagged_skid_fifo.sv
// tagged_skid_fifo: 2-entry {tag, data} FIFO with an occupancy count.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   in_valid     - write request. It is ignored when full unless a pop frees a slot
//   in_tag       - tag of the incoming entry
//   in_data      - payload of the incoming entry
//   out_ready    - downstream accepts the head when out_valid is high
//   out_valid    - head entry available (count != 0)
//   out_tag      - head tag
//   out_data     - head payload
//   count        - registered occupancy, 0..2
module tagged_skid_fifo #(
  parameter int TAG_W  = 2,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  localparam int ENTRY_W = TAG_W + DATA_W;

  // entry_p0 is always the head and entry_p1 the second-oldest entry, so
  // the output is a plain register read with no read-pointer mux.
  logic [ENTRY_W-1:0] entry_p0;
  logic [ENTRY_W-1:0] entry_p1;
  logic [ENTRY_W-1:0] in_entry;
  logic               pop;
  logic               push_ok;

  assign in_entry  = {in_tag, in_data};
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push_ok   = in_valid && ((count != 2'd2) || pop);
  assign {out_tag, out_data} = entry_p0;

  // ---- occupancy ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else begin
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // ---- storage ----
  // A pop shifts entry_p1 forward. A push lands in the first slot that is
  // free after any pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_p0 <= '0;
      entry_p1 <= '0;
    end else if (pop) begin
      if (count == 2'd2) begin
        entry_p0 <= entry_p1;
        if (push_ok) begin
          entry_p1 <= in_entry;
        end
      end else if (push_ok) begin
        entry_p0 <= in_entry;
      end
    end else if (push_ok) begin
      if (count == 2'd0) begin
        entry_p0 <= in_entry;
      end else begin
        entry_p1 <= in_entry;
      end
    end
  end

endmodule

// File: rtl/color_request_arbiter.sv
// color_request_arbiter: round-robin issue stage in front of the in-flight
// tracker. Each cycle it offers one candidate color (cand) to the tracker.
// The request is granted when that color is requesting, the tracker allows it,
// and the output buffer has room. A grant produces one push/push_tag pulse to
// the tracker and queues the tagged payload for the decoder.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_valid   - per-color request flags
//   req_data    - per-color payloads, color c at [c*DATA_WIDTH +: DATA_WIDTH]
//   req_ack     - one-hot acknowledge of the granted color, or zero
//   ready_tag   - candidate color presented to the tracker
//   ready       - tracker permission for ready_tag (same cycle)
//   push        - grant pulse to the tracker
//   push_tag    - granted color (equals cand when there is no grant)
//   out_valid   - output head available
//   out_data    - head payload
//   out_tag     - head color
//   out_ready   - downstream accepts the head
module color_request_arbiter
  import color_request_arbiter_pkg::*;
#(
  parameter  int COLORS      = COLORS_DEF,
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  localparam int LOG2_COLORS = log2(COLORS - 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [COLORS-1:0]            req_valid,
  input  logic [COLORS*DATA_WIDTH-1:0] req_data,
  output logic [COLORS-1:0]            req_ack,
  output logic [LOG2_COLORS-1:0]       ready_tag,
  input  logic                         ready,
  output logic                         push,
  output logic [LOG2_COLORS-1:0]       push_tag,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [LOG2_COLORS-1:0]       out_tag,
  input  logic                         out_ready
);

  logic [LOG2_COLORS-1:0] cand;
  logic [LOG2_COLORS-1:0] cand_next;
  logic [DATA_WIDTH-1:0]  cand_data;
  logic [1:0]             count;
  logic                   grant;

  assign ready_tag = cand;
  assign push_tag  = cand;
  assign cand_data = req_data[int'(cand)*DATA_WIDTH +: DATA_WIDTH];

  // Fullness is judged from the registered count only. This keeps out_ready
  // out of the req_ack/push path. The tracker sees push in the same cycle
  // it answered ready, so rst_n gates the grant. push and req_ack therefore
  // stay low during reset even with requests pending.
  assign grant = rst_n && req_valid[cand] && ready && (count != 2'd2);
  assign push  = grant;

  always_comb begin
    req_ack = '0;
    if (grant) begin
      req_ack[cand] = 1'b1;
    end
  end

  // Rotate-priority scan: first requester after cand, wrapping around so
  // cand itself is the last choice. COLORS is a power of two, so the index
  // wraps naturally in LOG2_COLORS bits. A denied or idle cand still advances.
  // A blocked color is therefore retried on the next pass rather than
  // starving the others.
  always_comb begin
    logic [LOG2_COLORS-1:0] idx;
    logic                   found;
    cand_next = cand + 1'b1;
    found     = 1'b0;
    idx       = cand;
    for (int i = 1; i <= COLORS; i++) begin
      idx = cand + LOG2_COLORS'(i);
      if (!found && req_valid[idx]) begin
        cand_next = idx;
        found     = 1'b1;
      end
    end
  end

  // ---- candidate pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
    end else begin
      cand <= cand_next;
    end
  end

  // ---- output buffer ----
  tagged_skid_fifo #(
    .TAG_W  (LOG2_COLORS),
    .DATA_W (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (grant),
    .in_tag    (cand),
    .in_data   (cand_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .count     (count)
  );

endmodule
